// File: rtl/bcd_7seg_scan.sv
// Multiplexed BCD to seven-segment display scanner.
// Time-shares a single segment bus across DIGITS digit enables. New data is
// staged in a pending register and only committed at a frame boundary so a
// frame never mixes old and new digits. Leading-zero suppression and an
// optional hex decode are applied at decode time.
module bcd_7seg_scan #(
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned CLK_DIV     = 1000,
  parameter bit          HEX_MODE    = 1'b0,
  parameter bit          SEG_ACT_LOW = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   digits_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  blank_lz,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  pending,
  output logic                  frame_done
);

  localparam int unsigned   PW        = $clog2(CLK_DIV);
  localparam int unsigned   IW        = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX   = IW'(DIGITS - 1);
  localparam logic [6:0]    SEG_OFF   = SEG_ACT_LOW ? 7'h7F : 7'h00;
  localparam logic          DP_OFF    = SEG_ACT_LOW;

  typedef enum logic {
    ST_IDLE,
    ST_HELD
  } pend_state_e;

  // Scan timing
  logic [PW-1:0] presc_q, presc_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          presc_tc;
  logic          idx_last;
  logic          wrap;

  // Data staging
  pend_state_e          state_q, state_d;
  logic [4*DIGITS-1:0]  pend_dig_q, pend_dig_d;
  logic [DIGITS-1:0]    pend_dp_q, pend_dp_d;
  logic [4*DIGITS-1:0]  disp_dig_q, disp_dig_d;
  logic [DIGITS-1:0]    disp_dp_q, disp_dp_d;

  // Output path
  logic [6:0]           seg_q, seg_d;
  logic                 dp_q, dp_d;
  logic [DIGITS-1:0]    an_q, an_d;
  logic                 fd_q;
  logic [6:0]           seg_raw;
  logic                 dp_raw;
  logic [3:0]           nib;
  logic                 sup;
  logic                 zero_run;
  logic [DIGITS-1:0]    zero_above;

  // Segment pattern for one code, active-high, {a,b,c,d,e,f,g}
  function automatic logic [6:0] decode_digit(input logic [3:0] code);
    logic [6:0] s;
    s = '0;
    case (code)
      4'h0: s = 7'b1111110;
      4'h1: s = 7'b0110000;
      4'h2: s = 7'b1101101;
      4'h3: s = 7'b1111001;
      4'h4: s = 7'b0110011;
      4'h5: s = 7'b1011011;
      4'h6: s = 7'b0011111;
      4'h7: s = 7'b1110000;
      4'h8: s = 7'b1111111;
      4'h9: s = 7'b1110011;
      4'hA: s = HEX_MODE ? 7'b1110111 : 7'b0000000;
      4'hB: s = HEX_MODE ? 7'b0011111 : 7'b0000000;
      4'hC: s = HEX_MODE ? 7'b1001110 : 7'b0000000;
      4'hD: s = HEX_MODE ? 7'b0111101 : 7'b0000000;
      4'hE: s = HEX_MODE ? 7'b1001111 : 7'b0000000;
      default: s = HEX_MODE ? 7'b1000111 : 7'b0000000;
    endcase
    return s;
  endfunction

  // Prescaler and digit index next-state
  always_comb begin
    presc_tc = (presc_q == PRESC_MAX);
    idx_last = (idx_q == IDX_MAX);
    wrap     = presc_tc && idx_last;
    presc_d  = presc_tc ? '0 : presc_q + PW'(1);
    idx_d    = idx_q;
    if (presc_tc) begin
      idx_d = idx_last ? '0 : idx_q + IW'(1);
    end
  end

  // Prescaler and digit index registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      idx_q   <= '0;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
    end
  end

  // Pending FSM and commit logic; a load coinciding with wrap bypasses
  // the pending register and goes straight to the display register
  always_comb begin
    state_d    = state_q;
    pend_dig_d = pend_dig_q;
    pend_dp_d  = pend_dp_q;
    disp_dig_d = disp_dig_q;
    disp_dp_d  = disp_dp_q;
    if (load) begin
      pend_dig_d = digits_in;
      pend_dp_d  = dp_in;
    end
    case (state_q)
      ST_IDLE: if (load && !wrap) state_d = ST_HELD;
      ST_HELD: if (wrap)          state_d = ST_IDLE;
      default:                    state_d = ST_IDLE;
    endcase
    if (wrap) begin
      if (load) begin
        disp_dig_d = digits_in;
        disp_dp_d  = dp_in;
      end else if (state_q == ST_HELD) begin
        disp_dig_d = pend_dig_q;
        disp_dp_d  = pend_dp_q;
      end
    end
  end

  // Pending state, staging and display registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pend_dig_q <= '0;
      pend_dp_q  <= '0;
      disp_dig_q <= '0;
      disp_dp_q  <= '0;
    end else begin
      state_q    <= state_d;
      pend_dig_q <= pend_dig_d;
      pend_dp_q  <= pend_dp_d;
      disp_dig_q <= disp_dig_d;
      disp_dp_q  <= disp_dp_d;
    end
  end

  // Decode is taken from next-state index/data so the registered outputs
  // line up with idx_q and frame_done lands on the digit-0 cycle
  always_comb begin
    an_d       = '0;
    nib        = '0;
    dp_raw     = 1'b0;
    sup        = 1'b0;
    zero_run   = 1'b1;
    zero_above = '0;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      zero_run = zero_run && (disp_dig_d[4*(DIGITS-1-k) +: 4] == 4'h0);
      zero_above[DIGITS-1-k] = zero_run;
    end
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (idx_d == IW'(i)) begin
        an_d[i] = 1'b1;
        nib     = disp_dig_d[4*i +: 4];
        dp_raw  = disp_dp_d[i];
        sup     = blank_lz && zero_above[i] && (i != 0);
      end
    end
    seg_raw = sup ? 7'b0000000 : decode_digit(nib);
    seg_d   = SEG_ACT_LOW ? ~seg_raw : seg_raw;
    dp_d    = SEG_ACT_LOW ? ~dp_raw : dp_raw;
  end

  // Registered display outputs and frame pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q <= SEG_OFF;
      dp_q  <= DP_OFF;
      an_q  <= '0;
      fd_q  <= 1'b0;
    end else begin
      seg_q <= seg_d;
      dp_q  <= dp_d;
      an_q  <= an_d;
      fd_q  <= wrap;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign pending    = (state_q == ST_HELD);
  assign frame_done = fd_q;

endmodule

// File: tb/tb_bcd_7seg_scan.sv
// Self-checking bench for bcd_7seg_scan: scoreboard of expected frames.
module tb_bcd_7seg_scan;

  logic        clk;
  logic        rst_n;
  logic        load;
  logic [15:0] digits_in;
  logic [3:0]  dp_in;
  logic        blank_lz;

  logic [6:0] seg, hx_seg, al_seg, d1_seg;
  logic       dp, hx_dp, al_dp, d1_dp;
  logic [3:0] an, hx_an, al_an;
  logic [0:0] d1_an;
  logic       pending, hx_pend, al_pend, d1_pend;
  logic       frame_done, hx_fd, al_fd, d1_fd;

  int unsigned checks = 0;
  int unsigned errors = 0;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic [6:0] seg_hx;
    logic [6:0] seg_al;
    logic       dp_al;
    logic       pend;
    logic       fd;
  } frame_t;

  frame_t exp_q[$];
  frame_t obs_q[$];

  bcd_7seg_scan #(.DIGITS(4), .CLK_DIV(4), .HEX_MODE(1'b0), .SEG_ACT_LOW(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .digits_in(digits_in), .dp_in(dp_in),
    .blank_lz(blank_lz), .seg(seg), .dp(dp), .an(an), .pending(pending), .frame_done(frame_done));

  bcd_7seg_scan #(.DIGITS(4), .CLK_DIV(4), .HEX_MODE(1'b1), .SEG_ACT_LOW(1'b0)) dut_hx (
    .clk(clk), .rst_n(rst_n), .load(load), .digits_in(digits_in), .dp_in(dp_in),
    .blank_lz(blank_lz), .seg(hx_seg), .dp(hx_dp), .an(hx_an), .pending(hx_pend), .frame_done(hx_fd));

  bcd_7seg_scan #(.DIGITS(4), .CLK_DIV(4), .HEX_MODE(1'b1), .SEG_ACT_LOW(1'b1)) dut_al (
    .clk(clk), .rst_n(rst_n), .load(load), .digits_in(digits_in), .dp_in(dp_in),
    .blank_lz(blank_lz), .seg(al_seg), .dp(al_dp), .an(al_an), .pending(al_pend), .frame_done(al_fd));

  bcd_7seg_scan #(.DIGITS(1), .CLK_DIV(3), .HEX_MODE(1'b0), .SEG_ACT_LOW(1'b0)) dut_d1 (
    .clk(clk), .rst_n(rst_n), .load(load), .digits_in(digits_in[3:0]), .dp_in(dp_in[0]),
    .blank_lz(blank_lz), .seg(d1_seg), .dp(d1_dp), .an(d1_an), .pending(d1_pend), .frame_done(d1_fd));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Build a segment vector from the letters a..g
  function automatic logic [6:0] segs(input string s);
    logic [6:0] r;
    r = '0;
    for (int i = 0; i < s.len(); i++) begin
      case (s[i])
        "a": r[6] = 1'b1;
        "b": r[5] = 1'b1;
        "c": r[4] = 1'b1;
        "d": r[3] = 1'b1;
        "e": r[2] = 1'b1;
        "f": r[1] = 1'b1;
        "g": r[0] = 1'b1;
        default: r = r;
      endcase
    end
    return r;
  endfunction

  function automatic logic [6:0] exp_seg(input logic [3:0] c, input bit hex);
    case (c)
      4'h0: return segs("abcdef");
      4'h1: return segs("bc");
      4'h2: return segs("abdeg");
      4'h3: return segs("abcdg");
      4'h4: return segs("bcfg");
      4'h5: return segs("acdfg");
      4'h6: return segs("cdefg");
      4'h7: return segs("abc");
      4'h8: return segs("abcdefg");
      4'h9: return segs("abcfg");
      4'hA: return hex ? segs("abcefg") : 7'h00;
      4'hB: return hex ? segs("cdefg")  : 7'h00;
      4'hC: return hex ? segs("adef")   : 7'h00;
      4'hD: return hex ? segs("bcdeg")  : 7'h00;
      4'hE: return hex ? segs("adefg")  : 7'h00;
      default: return hex ? segs("aefg") : 7'h00;
    endcase
  endfunction

  // Push the 16 expected cycles of one frame (4 digits x 4 cycles)
  task automatic push_exp(input logic [15:0] dig, input logic [3:0] dpv, input bit blank);
    int msd;
    frame_t e;
    logic [3:0] nib;
    bit bl;
    msd = -1;
    for (int i = 0; i < 4; i++) if (dig[4*i +: 4] != 4'h0) msd = i;
    for (int d = 0; d < 4; d++) begin
      nib = dig[4*d +: 4];
      bl  = blank && (d > 0) && (d > msd);
      for (int c = 0; c < 4; c++) begin
        e.an     = 4'(1 << d);
        e.seg    = bl ? 7'h00 : exp_seg(nib, 1'b0);
        e.dp     = dpv[d];
        e.seg_hx = bl ? 7'h00 : exp_seg(nib, 1'b1);
        e.seg_al = ~e.seg_hx;
        e.dp_al  = ~dpv[d];
        e.pend   = 1'b0;
        e.fd     = (d == 0) && (c == 0);
        exp_q.push_back(e);
      end
    end
  endtask

  // Record 16 cycles starting at a frame_done cycle (now=1: current cycle is one)
  task automatic capture(input bit now, output bit ok);
    int n;
    frame_t o;
    ok = 1'b1;
    n = 0;
    if (!now) begin
      do begin
        @(negedge clk);
        n++;
      end while (!frame_done && n < 64);
      ok = frame_done;
    end
    if (ok) begin
      for (int k = 0; k < 16; k++) begin
        o.an = an; o.seg = seg; o.dp = dp; o.seg_hx = hx_seg;
        o.seg_al = al_seg; o.dp_al = al_dp; o.pend = pending; o.fd = frame_done;
        obs_q.push_back(o);
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; load = 1'b0; digits_in = '0; dp_in = '0; blank_lz = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    checks++;
    if ({an, seg, dp, pending, frame_done} !== 14'h0) begin
      errors++; $display("FAIL reset_main: got %b required 0", {an, seg, dp, pending, frame_done});
    end
    checks++;
    if ({al_seg, al_dp, al_an, al_pend, al_fd} !== {8'hFF, 6'h0}) begin
      errors++; $display("FAIL reset_actlow: got %b required %b", {al_seg, al_dp, al_an, al_pend, al_fd}, {8'hFF, 6'h0});
    end
    checks++;
    if ({hx_an, hx_seg, hx_dp, hx_pend, hx_fd, d1_an, d1_seg, d1_dp, d1_pend, d1_fd} !== 25'h0) begin
      errors++; $display("FAIL reset_others: got %b required 0", {hx_an, hx_seg, hx_dp, hx_pend, hx_fd, d1_an, d1_seg, d1_dp, d1_pend, d1_fd});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({an, seg, dp, pending, frame_done} !== {4'b0001, segs("abcdef"), 3'b000}) begin
      errors++; $display("FAIL release_main: got %b required %b", {an, seg, dp, pending, frame_done}, {4'b0001, segs("abcdef"), 3'b000});
    end
    checks++;
    if ({al_an, al_seg, hx_an, hx_pend, hx_fd, al_pend, al_fd} !== {4'b0001, ~segs("abcdef"), 4'b0001, 4'b0000}) begin
      errors++; $display("FAIL release_hx_al: got %b", {al_an, al_seg, hx_an, hx_pend, hx_fd, al_pend, al_fd});
    end
    checks++;
    if ({d1_an, d1_seg, d1_pend} !== {1'b1, segs("abcdef"), 1'b0}) begin
      errors++; $display("FAIL release_d1: got %b required %b", {d1_an, d1_seg, d1_pend}, {1'b1, segs("abcdef"), 1'b0});
    end
  endtask

  task automatic test_load_1234();
    int n;
    int bad;
    bit ok;
    frame_t e, o;
    digits_in = 16'h1234; dp_in = 4'b0000; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    n = 0; bad = 0;
    while (!frame_done && n < 40) begin
      if (pending !== 1'b1) bad++;
      @(negedge clk);
      n++;
    end
    checks++;
    if (bad != 0 || n == 0) begin
      errors++; $display("FAIL load_pending_held: got %0d low cycles over %0d required 0 over >0", bad, n);
    end
    checks++;
    if (frame_done !== 1'b1) begin
      errors++; $display("FAIL load_wrap_timeout: got frame_done=%b required 1", frame_done);
    end
    push_exp(16'h1234, 4'b0000, 1'b0);
    capture(1'b1, ok);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL load_frame: got no sample required %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin errors++; $display("FAIL load_frame: got %h required %h", o, e); end
      end
    end
    obs_q.delete();
  endtask

  task automatic test_lz();
    bit ok;
    frame_t e, o;
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 0) begin
        digits_in = 16'h0042; dp_in = 4'b1100; blank_lz = 1'b1; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
      end else begin
        blank_lz = 1'b0;
      end
      capture(1'b0, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL lz_timeout: got no frame_done required pulse"); end
      push_exp(16'h0042, 4'b1100, blank_lz);
      while (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        if (obs_q.size() == 0) begin
          errors++; $display("FAIL lz_frame pass %0d: got no sample required %h", pass, e);
        end else begin
          o = obs_q.pop_front();
          if (o !== e) begin errors++; $display("FAIL lz_frame pass %0d: got %h required %h", pass, o, e); end
        end
      end
      obs_q.delete();
    end
  endtask

  task automatic test_wrap_load();
    bit ok;
    frame_t e, o;
    blank_lz = 1'b0;
    repeat (15) @(negedge clk);
    checks++;
    if ({an, pending, frame_done} !== {4'b1000, 2'b00}) begin
      errors++; $display("FAIL wrap_position: got %b required %b", {an, pending, frame_done}, {4'b1000, 2'b00});
    end
    digits_in = 16'h5678; dp_in = 4'b0001; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    push_exp(16'h5678, 4'b0001, 1'b0);
    capture(1'b1, ok);
    // load A then B before the wrap
    digits_in = 16'h1111; dp_in = 4'b1111; load = 1'b1;
    @(negedge clk);
    digits_in = 16'h9876; dp_in = 4'b0010;
    @(negedge clk);
    load = 1'b0;
    checks++;
    if (pending !== 1'b1) begin errors++; $display("FAIL overwrite_pending: got %b required 1", pending); end
    push_exp(16'h9876, 4'b0010, 1'b0);
    capture(1'b0, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL overwrite_timeout: got no frame_done required pulse"); end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL wrap_frame: got no sample required %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin errors++; $display("FAIL wrap_frame: got %h required %h", o, e); end
      end
    end
    obs_q.delete();
  endtask

  task automatic test_hex();
    logic [15:0] dig_t [3] = '{16'h0B00, 16'hFCDA, 16'hEBA9};
    logic [3:0]  dp_t  [3] = '{4'b0100, 4'b1010, 4'b0001};
    bit          bl_t  [3] = '{1'b1, 1'b0, 1'b1};
    bit ok;
    frame_t e, o;
    for (int t = 0; t < 3; t++) begin
      digits_in = dig_t[t]; dp_in = dp_t[t]; blank_lz = bl_t[t]; load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      capture(1'b0, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL hex_timeout case %0d: got no frame_done required pulse", t); end
      push_exp(dig_t[t], dp_t[t], bl_t[t]);
      while (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        if (obs_q.size() == 0) begin
          errors++; $display("FAIL hex_frame case %0d: got no sample required %h", t, e);
        end else begin
          o = obs_q.pop_front();
          if (o !== e) begin errors++; $display("FAIL hex_frame case %0d: got %h required %h", t, o, e); end
        end
      end
      obs_q.delete();
    end
  endtask

  task automatic test_d1();
    int bad_an, bad_seg, bad_gap, pulses, last;
    digits_in = 16'h0007; dp_in = 4'b0001; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (4) @(negedge clk);
    bad_an = 0; bad_seg = 0; bad_gap = 0; pulses = 0; last = -1;
    for (int k = 0; k < 12; k++) begin
      if (d1_an !== 1'b1) bad_an++;
      if ({d1_seg, d1_dp} !== {segs("abc"), 1'b1}) bad_seg++;
      if (d1_fd === 1'b1) begin
        pulses++;
        if (last >= 0 && (k - last) != 3) bad_gap++;
        last = k;
      end
      @(negedge clk);
    end
    checks++;
    if (bad_an != 0) begin errors++; $display("FAIL d1_an: got %0d bad cycles required 0", bad_an); end
    checks++;
    if (bad_seg != 0) begin errors++; $display("FAIL d1_seg: got %0d bad cycles required 0", bad_seg); end
    checks++;
    if (pulses != 4) begin errors++; $display("FAIL d1_pulses: got %0d required 4", pulses); end
    checks++;
    if (bad_gap != 0) begin errors++; $display("FAIL d1_gap: got %0d bad gaps required 0", bad_gap); end
  endtask

  task automatic test_reset_mid();
    int early;
    bit ok;
    frame_t e, o;
    blank_lz = 1'b0;
    digits_in = 16'h4321; dp_in = 4'b1111; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    checks++;
    if (pending !== 1'b1) begin errors++; $display("FAIL midreset_pending: got %b required 1", pending); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({an, seg, dp, pending, frame_done, al_seg, al_dp, d1_an} !== {14'h0, 8'hFF, 1'b0}) begin
      errors++; $display("FAIL midreset_async: got %b required %b", {an, seg, dp, pending, frame_done, al_seg, al_dp, d1_an}, {14'h0, 8'hFF, 1'b0});
    end
    @(negedge clk);
    rst_n = 1'b1;
    early = 0;
    for (int n = 1; n <= 16; n++) begin
      @(negedge clk);
      if (n < 16 && frame_done === 1'b1) early++;
    end
    checks++;
    if (early != 0) begin errors++; $display("FAIL midreset_early_fd: got %0d pulses required 0", early); end
    push_exp(16'h0000, 4'b0000, 1'b0);
    capture(1'b1, ok);
    checks++;
    if ({frame_done, pending, an} !== {2'b10, 4'b0001}) begin
      errors++; $display("FAIL midreset_period: got %b required %b", {frame_done, pending, an}, {2'b10, 4'b0001});
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL midreset_frame: got no sample required %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin errors++; $display("FAIL midreset_frame: got %h required %h", o, e); end
      end
    end
    obs_q.delete();
  endtask

  initial begin
    test_reset();
    test_load_1234();
    test_lz();
    test_wrap_load();
    test_hex();
    test_d1();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/bcd_7seg_scan.md
BCD_7SEG_SCAN -- requirements
Module: bcd_7seg_scan

Interface
REQ-001 Parameter DIGITS, default 4, sets the number of display digits; legal range is 1..8.
REQ-002 Parameter CLK_DIV, default 1000, sets the clk cycles each digit is driven; legal range is 2..65535.
REQ-003 Parameter HEX_MODE, default 0: when 0, codes 10-15 are invalid; when 1, they decode to A,b,C,d,E,F.
REQ-004 Parameter SEG_ACT_LOW, default 0: when 1, the seg and dp outputs are inverted; an is unaffected.
REQ-005 clk  input  1  is the single clock, rising edge.
REQ-006 rst_n  input  1  is the asynchronous, active-low reset.
REQ-007 load  input  1  captures digits_in and dp_in into the pending register when high at a clk edge.
REQ-008 digits_in  input  4*DIGITS  holds the BCD digits; nibble i is digit i, and digit 0 is least significant.
REQ-009 dp_in  input  DIGITS  holds the decimal-point enables, one bit per digit.
REQ-010 blank_lz  input  1  enables leading-zero suppression.
REQ-011 seg  output  7  drives segments {a,b,c,d,e,f,g}; seg[6]=a and seg[0]=g.
REQ-012 dp  output  1  drives the decimal-point segment of the currently selected digit.
REQ-013 an  output  DIGITS  is the one-hot digit enable, active-high.
REQ-014 pending  output  1  is high while loaded data is waiting to be committed to the display.
REQ-015 frame_done  output  1  is a one-cycle pulse asserted at each digit-index wrap.

Function
REQ-016 A prescaler SHALL count 0..CLK_DIV-1 and wrap to 0; the digit index SHALL advance on the cycle the prescaler equals CLK_DIV-1.
REQ-017 The digit index SHALL count 0..DIGITS-1 and wrap to 0 (a "wrap" cycle).
REQ-018 A load SHALL write the pending register and set pending=1; a second load before commit SHALL overwrite the pending data.
REQ-019 On a wrap cycle with pending=1, pending data SHALL be copied to the display register and pending cleared.
REQ-020 Load and wrap in the same cycle SHALL commit the new load data directly to the display register and leave pending=0.
REQ-021 Display data SHALL change only at wrap, so no frame mixes old and new digits.
REQ-022 seg, dp and an SHALL be registered and reflect the digit index with exactly 1 cycle of latency.
REQ-023 Decode, active-high, for codes 0-9:
  0=abcdef, 1=bc, 2=abdeg, 3=abcdg, 4=bcfg, 5=acdfg, 6=cdefg, 7=abc, 8=abcdefg, 9=abcfg.
REQ-024 When HEX_MODE=1, codes 10-15 SHALL decode as A=abcefg, b=cdefg, C=adef, d=bcdeg, E=adefg, F=aefg.
REQ-025 When HEX_MODE=0, codes 10-15 SHALL drive all segments off, with dp still driven from dp_in.
REQ-026 When blank_lz=1, every digit above the most-significant non-zero digit SHALL have segments off.
REQ-027 Digit 0 SHALL never be suppressed; blank_lz SHALL be sampled combinationally at every decode.
REQ-028 A suppressed digit SHALL still drive its an bit and its dp bit.
REQ-029 frame_done SHALL be registered and assert in the cycle after a wrap, coincident with an = one-hot bit 0.
REQ-030 DIGITS=1 SHALL wrap every prescaler period, and an SHALL stay 1 after the first cycle following reset.

Reset
REQ-031 While rst_n=0, the prescaler, digit index, pending register, display register, pending and frame_done SHALL all be 0.
REQ-032 While rst_n=0, seg and dp SHALL be inactive: all 0, or all 1 when SEG_ACT_LOW=1.
REQ-033 While rst_n=0, an SHALL be all 0.
REQ-034 On the first clk edge after rst_n rises, an SHALL become one-hot bit 0 and seg SHALL show "0" (abcdef).
REQ-035 Reset asserted mid-frame or mid-pending SHALL discard the pending data immediately, with no commit.

Verification (DIGITS=4, CLK_DIV=4, HEX_MODE=0, SEG_ACT_LOW=0 unless stated)
REQ-036 Reset release, then a load of 16'h1234 during frame 1 -> pending=1 until the wrap.
  - From frame 2 onward, an cycles 0001,0010,0100,1000 with 4 cycles on each digit.
  - seg sequence is 4=bcfg, 3=abcdg, 2=abdeg, 1=bc.
REQ-037 Load 16'h0042 with blank_lz=1 -> digits 3 and 2 show seg off while their an bits still assert; digit 1 shows 4 and digit 0 shows 2.
  - The same case with blank_lz=0 -> digits 3 and 2 show "0".
REQ-038 Load in the exact wrap cycle -> new data is visible in that frame's digit 0 and pending never rises.
  - A second case issues load A, then load B before the wrap -> only B is ever displayed.
REQ-039 Digit code 4'hB -> seg off with HEX_MODE=0; seg=cdefg (b) with HEX_MODE=1.
  - The same stimulus with SEG_ACT_LOW=1 -> seg bitwise inverted.
REQ-040 Assert rst_n=0 with pending=1 in mid-frame -> outputs are inactive asynchronously.
  - After release, the display shows "0000" and pending=0.
  - The check runs frame_done count=0 until the first wrap, then confirms frame_done pulses one cycle per 16 clk.
